// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared constants and helpers for the register file write arbiter
package regfile_arb_pkg;

  localparam int NREQ_DEFAULT = 3;
  localparam int REG_IDX_W    = 4;
  localparam int NUM_REGS     = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t PC_IDX = 4'd15;

  function automatic logic is_pc(input reg_idx_t idx);
    return idx == PC_IDX;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - rotating-priority one-hot grant; priority starts at ptr and ascends modulo NREQ
module rr_grant #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  input  logic             hold,
  output logic [NREQ-1:0]  grant
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr and k are both below NREQ, so one subtraction wraps the sum
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) begin
        sum = sum - (PTR_W+1)'(NREQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    if (hold) begin
      grant = '0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter onto the register file write port
// Optional pending-write scoreboard enabled by REGFILE_ARB_SCOREBOARD_EN.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*REG_IDX_W-1:0] req_addr,
  input  logic [NREQ*N-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      WE3,
  output logic [REG_IDX_W-1:0]      A3,
  output logic [N-1:0]              WD3,
  output logic                      err_pc,
  input  logic                      claim_valid,
  input  logic [REG_IDX_W-1:0]      claim_addr,
  output logic [NUM_REGS-1:0]       busy
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             we3_q, we3_d;
  reg_idx_t         a3_q, a3_d;
  logic [N-1:0]     wd3_q, wd3_d;
  logic             err_pc_q, err_pc_d;

  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [PTR_W-1:0] gidx;
  reg_idx_t         sel_addr;
  logic [N-1:0]     sel_data;

  // Reset forces the grant low so nothing transfers during the reset cycle
  rr_grant #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_grant (
    .valid (req_valid),
    .ptr   (ptr_q),
    .hold  (hold | rst),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx     = PTR_W'(i);
        sel_addr = req_addr[i*REG_IDX_W +: REG_IDX_W];
        sel_data = req_data[i*N +: N];
      end
    end
    xfer = |(req_valid & grant);

    ptr_d    = ptr_q;
    we3_d    = 1'b0;
    err_pc_d = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    if (xfer) begin
      ptr_d = (gidx == PTR_W'(NREQ-1)) ? '0 : gidx + 1'b1;
      // r15 belongs to the PC: accept the beat but drop the write
      if (is_pc(sel_addr)) begin
        err_pc_d = 1'b1;
      end else begin
        we3_d = 1'b1;
        a3_d  = sel_addr;
        wd3_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      err_pc_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      err_pc_q <= err_pc_d;
    end
  end

  assign WE3    = we3_q;
  assign A3     = a3_q;
  assign WD3    = wd3_q;
  assign err_pc = err_pc_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // A claim applied after the clear so it wins on the same index
  always_comb begin
    busy_d = busy_q;
    if (we3_q) begin
      busy_d[a3_q] = 1'b0;
    end
    if (claim_valid && !is_pc(claim_addr)) begin
      busy_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_claim;
  assign unused_claim = ^{claim_valid, claim_addr};
  assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 3;

  logic              clk;
  logic              rst;
  logic              hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*4-1:0] req_addr;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              WE3;
  logic [3:0]        A3;
  logic [N-1:0]      WD3;
  logic              err_pc;
  logic              claim_valid;
  logic [3:0]        claim_addr;
  logic [15:0]       busy;

  typedef struct {
    logic         we;
    logic [3:0]   a3;
    logic [N-1:0] wd3;
    logic         err;
    logic [15:0]  busy;
  } exp_t;

  exp_t sbq[$];

  logic         m_we;
  logic [3:0]   m_a3;
  logic [N-1:0] m_wd3;
  logic [15:0]  m_busy;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .WE3         (WE3),
    .A3          (A3),
    .WD3         (WD3),
    .err_pc      (err_pc),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [N-1:0] d);
    req_addr[i*4 +: 4] = a;
    req_data[i*N +: N] = d;
  endtask

  // One clock: check the grant, predict the registered outputs, then compare after the edge
  task automatic step(input logic [NREQ-1:0] exp_ready, input string tag);
    exp_t           e;
    exp_t           got;
    logic [NREQ-1:0] x;
    int             gi;
    logic [3:0]     a;
    logic [15:0]    b;
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    x  = req_valid & exp_ready;
    gi = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (x[i]) gi = i;
    end
    if (rst) begin
      e.we = 1'b0; e.a3 = '0; e.wd3 = '0; e.err = 1'b0; e.busy = '0;
    end else begin
      e.we = 1'b0; e.err = 1'b0; e.a3 = m_a3; e.wd3 = m_wd3;
      if (gi >= 0) begin
        a = req_addr[gi*4 +: 4];
        if (a == 4'd15) begin
          e.err = 1'b1;
        end else begin
          e.we  = 1'b1;
          e.a3  = a;
          e.wd3 = req_data[gi*N +: N];
        end
      end
`ifdef REGFILE_ARB_SCOREBOARD_EN
      b = m_busy;
      if (m_we) b[m_a3] = 1'b0;
      if (claim_valid && claim_addr != 4'd15) b[claim_addr] = 1'b1;
`else
      b = '0;
`endif
      e.busy = b;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk({tag, ".WE3"},    64'(WE3),    64'(got.we));
    chk({tag, ".A3"},     64'(A3),     64'(got.a3));
    chk({tag, ".WD3"},    64'(WD3),    64'(got.wd3));
    chk({tag, ".err_pc"}, 64'(err_pc), 64'(got.err));
    chk({tag, ".busy"},   64'(busy),   64'(got.busy));
    m_we   = got.we;
    m_a3   = got.a3;
    m_wd3  = got.wd3;
    m_busy = got.busy;
  endtask

  initial begin
    m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_busy = '0;
    rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
    req_addr = '0; req_data = '0;
    claim_valid = 1'b0; claim_addr = '0;

    step(3'b000, "rst0");
    step(3'b000, "rst1");
    rst = 1'b0;

    req_valid = 3'b001;
    set_req(0, 4'd4, 32'hDEADBEEF);
    step(3'b001, "w4");
    req_valid = 3'b000;
    step(3'b000, "idle");

    rst = 1'b1; req_valid = 3'b111;
    set_req(0, 4'd1, 32'hA0000001);
    set_req(1, 4'd2, 32'hA0000002);
    set_req(2, 4'd3, 32'hA0000003);
    step(3'b000, "rst2");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(3'b001 << (k % 3), "rr");
    end

    req_valid = 3'b101;
    step(3'b001, "gap0");
    step(3'b100, "gap2");

    req_valid = 3'b010;
    set_req(1, 4'd15, 32'h00001515);
    step(3'b010, "pc");
    req_valid = 3'b111;
    set_req(1, 4'd9, 32'h00000909);
    step(3'b100, "ptr2");

    req_valid = 3'b001;
    step(3'b001, "pre_hold");
    hold = 1'b1; req_valid = 3'b111;
    step(3'b000, "hold0");
    step(3'b000, "hold1");
    step(3'b000, "hold2");
    hold = 1'b0;
    step(3'b010, "resume");

    req_valid = 3'b000;
    claim_valid = 1'b1; claim_addr = 4'd5;
    step(3'b000, "claim5");
    claim_addr = 4'd15;
    step(3'b000, "claim15");
    claim_valid = 1'b0;
    req_valid = 3'b001;
    set_req(0, 4'd5, 32'h00000055);
    step(3'b001, "w5");
    req_valid = 3'b000;
    claim_valid = 1'b1; claim_addr = 4'd5;
    step(3'b000, "w5claim");
    claim_valid = 1'b0;
    req_valid = 3'b010;
    set_req(1, 4'd5, 32'h00000066);
    step(3'b010, "w5b");
    req_valid = 3'b000;
    step(3'b000, "clr5");

    req_valid = 3'b100;
    set_req(2, 4'd7, 32'h00000077);
    claim_valid = 1'b1; claim_addr = 4'd7;
    step(3'b100, "w7");
    claim_valid = 1'b0;
    rst = 1'b1; req_valid = 3'b111;
    step(3'b000, "rst3");
    rst = 1'b0;
    step(3'b001, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data width matching the register file write port.
REQ-002 SHALL have parameter NREQ, default 3, number of write requesters (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port hold  input  1  freezes arbitration; no grants while high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-007 SHALL have port req_addr  input  NREQ x 4  per-requester destination register index.
REQ-008 SHALL have port req_data  input  NREQ x N  per-requester write data.
REQ-009 SHALL have port req_ready  output  NREQ  one-hot grant; transfer = valid && ready.
REQ-010 SHALL have port WE3  output  1  register file write enable.
REQ-011 SHALL have port A3  output  4  register file write address.
REQ-012 SHALL have port WD3  output  N  register file write data.
REQ-013 SHALL have port err_pc  output  1  one-cycle pulse on a dropped write to r15.
REQ-014 SHALL have ports claim_valid/claim_addr  input  1/4  scoreboard claim of a destination register.
REQ-015 SHALL have port busy  output  16  per-register pending-write flags.

Function
REQ-016 SHALL keep a round-robin pointer ptr (0..NREQ-1); priority starts at ptr and ascends modulo NREQ.
REQ-017 SHALL drive req_ready combinationally: at most one bit, to the highest-priority valid requester; all zero when hold or rst is high.
REQ-018 SHALL, after a transfer from requester i, set ptr to i+1, wrapping NREQ-1 to 0; ptr holds when no transfer.
REQ-019 SHALL register the transferred request with one-cycle latency: next cycle WE3=1, A3=addr, WD3=data.
REQ-020 SHALL drive WE3=0 in any cycle following no transfer; A3/WD3 hold their last values.
REQ-021 SHALL accept (ready=1) a request with addr 15 but keep WE3=0 and pulse err_pc for one cycle; r15 is PC-owned.
REQ-022 SHALL sustain one write per cycle under continuous requests (no bubble).
REQ-023 SHALL treat requester data/addr as don't-care while its valid is low; valid SHALL NOT depend on ready.

Reset
REQ-024 SHALL on rst set ptr=0, WE3=0, A3=0, WD3=0, err_pc=0, busy=0, req_ready=0.
REQ-025 SHALL discard any transfer presented in the reset cycle; a registered write pending at rst is cancelled (WE3=0 next cycle).

Configuration
REQ-026 SHALL, with REGFILE_ARB_SCOREBOARD_EN defined, set busy[claim_addr] on claim_valid and clear busy[A3] in the cycle WE3=1.
REQ-027 SHALL, on simultaneous claim and clear of the same index, leave the bit set (claim wins); claims to index 15 are ignored.
REQ-028 SHALL, without REGFILE_ARB_SCOREBOARD_EN, tie busy to 0 and ignore claim_valid/claim_addr; all other behaviour identical.

Structure
REQ-029 SHALL take NREQ default, register-index width (4), PC index (15) and register count (16) from a shared package regfile_arb_pkg.
REQ-030 SHALL implement rotating-priority grant selection in one sub-module rr_grant (inputs valid, ptr, hold; output one-hot grant).
REQ-031 SHALL connect WE3/A3/WD3 directly to the register file write port without further logic.

Verification
REQ-032 SHALL cover: reset, req_valid=3'b001, addr=4, data=0xDEADBEEF -> ready=001; next cycle WE3=1, A3=4, WD3=0xDEADBEEF.
REQ-033 SHALL cover: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; WE3=1 on every cycle from cycle 2.
REQ-034 SHALL cover: requester 1 writes addr 15 -> ready[1]=1, next cycle WE3=0, err_pc=1 for one cycle, ptr=2.
REQ-035 SHALL cover: hold=1 with valid=111 for 3 cycles -> ready=000, WE3=0, ptr unchanged; hold drop -> grant resumes at saved ptr.
REQ-036 SHALL cover: rst asserted in the cycle after a transfer to addr 7 -> WE3=0, busy=0, ptr=0 next cycle.
REQ-037 SHALL cover (scoreboard on): claim addr 5, later write to 5 with concurrent claim of 5 -> busy[5] stays 1; with macro off busy=0 throughout.
